// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall/flush scheduler with bounded D-memory wait and saturating statistics
module pipe_stall_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic [9:0]       id_rsrt_i,
  input  logic             id_uses_rt_i,
  input  logic             id_branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  input  logic             cnt_clr_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_bubble_o,
  output logic             exmem_write_o,
  output logic             memwb_bubble_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  localparam int WW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
  state_t            state_q, state_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q, stall_d, flush_q, flush_d;
  logic              freeze, lu, err, halt, adv, stall_inc;
  always_comb begin
    err       = state_q == ERROR;
    freeze    = state_q == MEM_WAIT || (state_q == RUN && dmem_req_i && !dmem_ready_i);
    lu        = ex_memread_i && ex_rt_i != 5'd0 &&
                (ex_rt_i == id_rsrt_i[9:5] || (id_uses_rt_i && ex_rt_i == id_rsrt_i[4:0]));
    halt      = rst_i || err;
    adv       = !halt && !freeze;
    pc_write_o     = adv && !lu;
    ifid_write_o   = adv && !lu;
    ifid_flush_o   = adv && !lu && id_branch_taken_i;
    idex_write_o   = adv;
    idex_bubble_o  = adv && lu;
    exmem_write_o  = adv;
    memwb_bubble_o = !halt && freeze;
    halted_o       = err;
    stall_cnt_o    = stall_q;
    flush_cnt_o    = flush_q;
    stall_inc = (freeze || lu) && !err;
    stall_d   = cnt_clr_i ? '0 : (stall_inc && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
    flush_d   = cnt_clr_i ? '0 : (ifid_flush_o && !(&flush_q)) ? flush_q + 1'b1 : flush_q;
    state_d   = state_q;
    wait_d    = wait_q;
    if (state_q == RUN && dmem_req_i && !dmem_ready_i) begin
      state_d = MEM_WAIT;
      wait_d  = WW'(1);
    end else if (state_q == MEM_WAIT) begin
      if (dmem_ready_i) state_d = RUN;
      else if (MEM_TIMEOUT != 0 && wait_q == WW'(MEM_TIMEOUT)) state_d = ERROR;
      else wait_d = wait_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed scenario tests for the stall/flush scheduler
module tb_pipe_stall_ctrl;
  localparam logic [6:0] NORM = 7'b1101010;
  localparam logic [6:0] BR   = 7'b1111010;
  localparam logic [6:0] LU   = 7'b0001110;
  localparam logic [6:0] FRZ  = 7'b0000001;
  localparam logic [6:0] HALT = 7'b0000000;
  logic clk = 0, rst = 1;
  logic ex_memread = 0, uses_rt = 0, br = 0, req = 0, rdy = 0, clr = 0;
  logic [4:0] ex_rt = 0;
  logic [9:0] rsrt = 0;
  logic pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b, halted;
  logic s_pc_w, s_ifid_w, s_ifid_f, s_idex_w, s_idex_b, s_exmem_w, s_memwb_b, s_halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0] s_stall_cnt, s_flush_cnt;
  logic [6:0] ctl;
  int n_cmp = 0, n_err = 0;
  assign ctl = {pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b};
  always #5 clk = ~clk;
  pipe_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .id_rsrt_i(rsrt),
    .id_uses_rt_i(uses_rt), .id_branch_taken_i(br), .dmem_req_i(req), .dmem_ready_i(rdy),
    .cnt_clr_i(clr), .pc_write_o(pc_w), .ifid_write_o(ifid_w), .ifid_flush_o(ifid_f),
    .idex_write_o(idex_w), .idex_bubble_o(idex_b), .exmem_write_o(exmem_w),
    .memwb_bubble_o(memwb_b), .halted_o(halted), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt));
  pipe_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) u_sat (
    .clk_i(clk), .rst_i(rst), .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .id_rsrt_i(rsrt),
    .id_uses_rt_i(uses_rt), .id_branch_taken_i(br), .dmem_req_i(req), .dmem_ready_i(rdy),
    .cnt_clr_i(clr), .pc_write_o(s_pc_w), .ifid_write_o(s_ifid_w), .ifid_flush_o(s_ifid_f),
    .idex_write_o(s_idex_w), .idex_bubble_o(s_idex_b), .exmem_write_o(s_exmem_w),
    .memwb_bubble_o(s_memwb_b), .halted_o(s_halted), .stall_cnt_o(s_stall_cnt),
    .flush_cnt_o(s_flush_cnt));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    ex_memread = 0; ex_rt = 0; rsrt = 0; uses_rt = 0; br = 0; req = 0; rdy = 0; clr = 0;
  endtask

  task automatic set_lu;
    ex_memread = 1; ex_rt = 5'd5; rsrt = {5'd5, 5'd0}; uses_rt = 0;
  endtask

  task automatic clear_counters;
    idle(); clr = 1;
    tick();
    clr = 0;
  endtask

  task automatic test_reset;
    idle(); set_lu(); br = 1; req = 1; rst = 1;
    #2;
    n_cmp++; if (ctl !== HALT) begin n_err++; $display("FAIL reset_ctl got %b exp %b", ctl, HALT); end
    tick(); tick();
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b exp 0", halted); end
    n_cmp++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    idle(); rst = 0;
    #2;
    n_cmp++; if (ctl !== NORM) begin n_err++; $display("FAIL reset_release got %b exp %b", ctl, NORM); end
    tick();
  endtask

  task automatic test_load_use;
    clear_counters();
    set_lu();
    #2;
    n_cmp++; if (ctl !== LU) begin n_err++; $display("FAIL lu_ctl got %b exp %b", ctl, LU); end
    tick();
    ex_memread = 0;
    #2;
    n_cmp++; if (ctl !== NORM) begin n_err++; $display("FAIL lu_release got %b exp %b", ctl, NORM); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt); end
    tick();
    ex_memread = 1; ex_rt = 0; rsrt = 0;
    #2;
    n_cmp++; if (ctl !== NORM) begin n_err++; $display("FAIL lu_r0 got %b exp %b", ctl, NORM); end
    tick();
    ex_rt = 5'd7; rsrt = {5'd1, 5'd7}; uses_rt = 0;
    #2;
    n_cmp++; if (ctl !== NORM) begin n_err++; $display("FAIL lu_rt_unused got %b exp %b", ctl, NORM); end
    tick();
    uses_rt = 1;
    #2;
    n_cmp++; if (ctl !== LU) begin n_err++; $display("FAIL lu_rt_used got %b exp %b", ctl, LU); end
    tick();
    idle();
    n_cmp++; if (stall_cnt !== 16'd2) begin n_err++; $display("FAIL lu_stall_total got %0d exp 2", stall_cnt); end
  endtask

  task automatic test_dmem_wait;
    clear_counters();
    req = 1; set_lu(); br = 1;
    for (int i = 0; i < 4; i++) begin
      rdy = (i == 3);
      #2;
      n_cmp++; if (ctl !== FRZ) begin n_err++; $display("FAIL dmem_freeze%0d got %b exp %b", i, ctl, FRZ); end
      tick();
    end
    idle();
    #2;
    n_cmp++; if (ctl !== NORM) begin n_err++; $display("FAIL dmem_release got %b exp %b", ctl, NORM); end
    n_cmp++; if (stall_cnt !== 16'd4 || flush_cnt !== 16'd0) begin
      n_err++; $display("FAIL dmem_cnt got %0d/%0d exp 4/0", stall_cnt, flush_cnt); end
    req = 1; rdy = 1;
    #2;
    n_cmp++; if (ctl !== NORM) begin n_err++; $display("FAIL dmem_single got %b exp %b", ctl, NORM); end
    tick();
    idle();
  endtask

  task automatic test_timeout;
    clear_counters();
    req = 1; rdy = 0;
    for (int i = 0; i < 5; i++) begin
      #2;
      n_cmp++; if (ctl !== FRZ || halted !== 1'b0) begin
        n_err++; $display("FAIL tmo_wait%0d got %b/%b exp %b/0", i, ctl, halted, FRZ); end
      tick();
    end
    br = 1;
    #2;
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL tmo_halted got %b exp 1", halted); end
    n_cmp++; if (ctl !== HALT) begin n_err++; $display("FAIL tmo_ctl got %b exp %b", ctl, HALT); end
    tick(); rdy = 1; set_lu(); tick();
    #2;
    n_cmp++; if (ctl !== HALT || halted !== 1'b1) begin
      n_err++; $display("FAIL tmo_sticky got %b/%b exp %b/1", ctl, halted, HALT); end
    n_cmp++; if (stall_cnt !== 16'd5 || flush_cnt !== 16'd0) begin
      n_err++; $display("FAIL tmo_cnt got %0d/%0d exp 5/0", stall_cnt, flush_cnt); end
    idle(); rst = 1;
    tick();
    rst = 0;
    #2;
    n_cmp++; if (halted !== 1'b0 || ctl !== NORM) begin
      n_err++; $display("FAIL tmo_reset got %b/%b exp 0/%b", halted, ctl, NORM); end
    n_cmp++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      n_err++; $display("FAIL tmo_reset_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    tick();
  endtask

  task automatic test_branch;
    clear_counters();
    br = 1;
    #2;
    n_cmp++; if (ctl !== BR) begin n_err++; $display("FAIL br_ctl got %b exp %b", ctl, BR); end
    tick();
    n_cmp++; if (flush_cnt !== 16'd1) begin n_err++; $display("FAIL br_flush_cnt got %0d exp 1", flush_cnt); end
    set_lu();
    #2;
    n_cmp++; if (ctl !== LU) begin n_err++; $display("FAIL br_lu_ctl got %b exp %b", ctl, LU); end
    tick();
    n_cmp++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin
      n_err++; $display("FAIL br_lu_cnt got %0d/%0d exp 1/1", flush_cnt, stall_cnt); end
    idle();
  endtask

  task automatic test_back_to_back;
    clear_counters();
    br = 1;
    tick(); tick();
    set_lu(); br = 0;
    tick();
    ex_memread = 0; br = 1;
    #2;
    n_cmp++; if (ctl !== BR) begin n_err++; $display("FAIL b2b_br got %b exp %b", ctl, BR); end
    tick();
    idle();
    n_cmp++; if (flush_cnt !== 16'd3 || stall_cnt !== 16'd1) begin
      n_err++; $display("FAIL b2b_cnt got %0d/%0d exp 3/1", flush_cnt, stall_cnt); end
  endtask

  task automatic test_saturate;
    logic [1:0] exp_s;
    clear_counters();
    set_lu();
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_s = (i >= 2) ? 2'd3 : 2'(i + 1);
      n_cmp++; if (s_stall_cnt !== exp_s) begin
        n_err++; $display("FAIL sat_step%0d got %0d exp %0d", i, s_stall_cnt, exp_s); end
    end
    n_cmp++; if (stall_cnt !== 16'd5) begin n_err++; $display("FAIL sat_wide got %0d exp 5", stall_cnt); end
    clr = 1;
    tick();
    n_cmp++; if (s_stall_cnt !== 2'd0 || stall_cnt !== 16'd0) begin
      n_err++; $display("FAIL sat_clr got %0d/%0d exp 0/0", s_stall_cnt, stall_cnt); end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_dmem_wait();
    test_timeout();
    test_branch();
    test_back_to_back();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
